// File: rtl/simon_host_if.sv
// rtl/simon_host_if.sv - host-side word-stream initiator for the SIMON 32/64 core
//
// Purpose: assembles host words into a key (M words) or a data block (2 words),
// issues it to the cipher core over the newKey/newData handshake, captures the
// result block and streams it back out one word at a time.
//
// Ports:
//   clk, R                 clock, synchronous active-high reset
//   in_valid/in_ready      host word handshake, in_word carries the word
//   in_is_key, in_dec      transfer type and direction, sampled on the first word
//   out_valid/out_ready    result word handshake, out_word carries the word
//   key_ok, busy, err      status: key loaded, not idle, one-cycle error pulse
//   newKey, newData        registered requests to the core
//   enc_dec, readData      core direction, one-cycle result-consumed pulse
//   key, inData            key and block presented to the core
//   loadKey, loadData      core request acknowledges
//   doneKey, doneData      core completion strobes, outData is the core result
//
// Optional feature: define SIMON_HOST_TIMEOUT_EN to abandon a core request that
// stays unanswered for TIMEOUT cycles.
module simon_host_if #(
    parameter int N       = 16,
    parameter int M       = 4,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_word,
    input  logic             in_is_key,
    input  logic             in_dec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_word,
    output logic             key_ok,
    output logic             busy,
    output logic             err,
    output logic             newKey,
    output logic             newData,
    output logic             enc_dec,
    output logic             readData,
    output logic [M*N-1:0]   key,
    output logic [2*N-1:0]   inData,
    input  logic             loadKey,
    input  logic             loadData,
    input  logic             doneKey,
    input  logic             doneData,
    input  logic [2*N-1:0]   outData
);

    localparam int CW = (M > 2) ? $clog2(M) : 1;

    generate
        if ((2 ** TW) <= TIMEOUT) begin : g_tw_check
            $error("TW is too narrow to hold TIMEOUT");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_KREQ, S_KWAIT, S_DREQ, S_DWAIT, S_READ, S_OUT
    } state_t;

    state_t          state, state_next;
    logic            is_key_q;
    logic            dir_q;
    logic [CW-1:0]   word_cnt;
    logic [CW-1:0]   key_sel;
    logic [2*N-1:0]  res_buf;
    logic            out_sel;
    logic            accept;
    logic            cur_is_key;
    logic            last_word;
    logic            key_ok_next;
    logic            err_next;
    logic            timeout_hit;

    // Handshaking is held off while reset is asserted so every output reads 0.
    assign in_ready   = !R && (state == S_IDLE || state == S_COLLECT);
    assign accept     = in_valid && in_ready;
    // The first word decides the transfer type; later words follow the latched type.
    assign cur_is_key = (state == S_IDLE) ? in_is_key : is_key_q;
    assign last_word  = cur_is_key ? (word_cnt == CW'(M - 1)) : (word_cnt == CW'(1));
    // Key words fill from the most significant slot downwards.
    assign key_sel    = CW'(M - 1) - word_cnt;
    assign out_valid  = (state == S_OUT);
    assign out_word   = out_sel ? res_buf[N-1:0] : res_buf[2*N-1:N];
    assign busy       = (state != S_IDLE);

`ifdef SIMON_HOST_TIMEOUT_EN
    logic [TW-1:0] tcnt;
    logic          in_wait;

    assign in_wait     = (state == S_KREQ) || (state == S_KWAIT) ||
                         (state == S_DREQ) || (state == S_DWAIT);
    assign timeout_hit = in_wait && (tcnt == TW'(TIMEOUT - 1));

    // Any state change restarts the count, so it always measures time spent in
    // the current wait state.
    always_ff @(posedge clk) begin
        if (R) begin
            tcnt <= '0;
        end else if (state_next != state) begin
            tcnt <= '0;
        end else if (in_wait) begin
            tcnt <= tcnt + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        key_ok_next = key_ok;
        err_next    = 1'b0;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (accept) begin
                    if (cur_is_key && state == S_IDLE) begin
                        key_ok_next = 1'b0;
                    end
                    if (!last_word) begin
                        state_next = S_COLLECT;
                    end else if (cur_is_key) begin
                        state_next = S_KREQ;
                    end else if (key_ok) begin
                        state_next = S_DREQ;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_KREQ: begin
                if (loadKey) begin
                    if (doneKey) begin
                        key_ok_next = 1'b1;
                        state_next  = S_IDLE;
                    end else begin
                        state_next  = S_KWAIT;
                    end
                end
            end
            S_KWAIT: begin
                if (doneKey) begin
                    key_ok_next = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_DREQ:  if (loadData) state_next = S_DWAIT;
            S_DWAIT: if (doneData) state_next = S_READ;
            S_READ:  state_next = S_OUT;
            S_OUT:   if (out_ready && out_sel) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // A genuine completion in the same cycle wins over the timeout.
        if (timeout_hit && state_next == state) begin
            err_next   = 1'b1;
            state_next = S_IDLE;
            if (state == S_KREQ || state == S_KWAIT) begin
                key_ok_next = 1'b0;
            end
        end
    end

    // Core-facing strobes are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (R) begin
            state    <= S_IDLE;
            key_ok   <= 1'b0;
            err      <= 1'b0;
            newKey   <= 1'b0;
            newData  <= 1'b0;
            enc_dec  <= 1'b0;
            readData <= 1'b0;
        end else begin
            state    <= state_next;
            key_ok   <= key_ok_next;
            err      <= err_next;
            newKey   <= (state_next == S_KREQ);
            newData  <= (state_next == S_DREQ);
            readData <= (state_next == S_READ);
            if (state_next == S_DREQ && state != S_DREQ) begin
                enc_dec <= dir_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            is_key_q <= 1'b0;
            dir_q    <= 1'b0;
            word_cnt <= '0;
            key      <= '0;
            inData   <= '0;
            res_buf  <= '0;
            out_sel  <= 1'b0;
        end else begin
            if (accept) begin
                if (state == S_IDLE) begin
                    is_key_q <= in_is_key;
                    dir_q    <= in_dec;
                end
                if (cur_is_key) begin
                    key[int'(key_sel) * N +: N] <= in_word;
                end else if (!word_cnt[0]) begin
                    inData[2*N-1:N] <= in_word;
                end else begin
                    inData[N-1:0] <= in_word;
                end
                word_cnt <= last_word ? '0 : word_cnt + CW'(1);
            end
            if (state == S_DWAIT && doneData) begin
                res_buf <= outData;
            end
            if (state == S_READ) begin
                out_sel <= 1'b0;
            end else if (state == S_OUT && out_ready) begin
                out_sel <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_simon_host_if.sv
// tb/tb_simon_host_if.sv - self-checking bench for simon_host_if with a behavioural SIMON 32/64 core
module tb_simon_host_if;

    localparam int N = 16;
    localparam int M = 4;
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    logic            clk = 1'b0;
    logic            R = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N-1:0]    in_word = '0;
    logic            in_is_key = 1'b0;
    logic            in_dec = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    out_word;
    logic            key_ok, busy, err;
    logic            newKey, newData, enc_dec, readData;
    logic [M*N-1:0]  key;
    logic [2*N-1:0]  inData;
    logic            loadKey = 1'b0, loadData = 1'b0, doneKey = 1'b0, doneData = 1'b0;
    logic [2*N-1:0]  outData = '0;

    int n_pass = 0;
    int n_total = 0;
    int k_ld = 2, k_dn = 5, d_ld = 1, d_dn = 4;
    int rd_cycles = 0, nd_cycles = 0;
    logic [63:0] exp_key = '0;

    always #5 clk = ~clk;

    simon_host_if #(.N(N), .M(M)) dut (
        .clk(clk), .R(R),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_is_key(in_is_key), .in_dec(in_dec),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .key_ok(key_ok), .busy(busy), .err(err),
        .newKey(newKey), .newData(newData), .enc_dec(enc_dec), .readData(readData),
        .key(key), .inData(inData),
        .loadKey(loadKey), .loadData(loadData), .doneKey(doneKey), .doneData(doneData),
        .outData(outData)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] rol(input logic [15:0] x, input int s);
        return (x << s) | (x >> (16 - s));
    endfunction

    function automatic logic [15:0] ror(input logic [15:0] x, input int s);
        return (x >> s) | (x << (16 - s));
    endfunction

    // Reference SIMON 32/64: 32 rounds, key schedule from z0, block = {x, y}.
    function automatic logic [31:0] simon(input logic [63:0] kin, input logic [31:0] blk, input logic dec);
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        logic [61:0] z;
        z = Z0;
        for (int i = 0; i < 4; i++) k[i] = kin[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = ror(k[i-1], 3) ^ k[i-3];
            t = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
        x = blk[31:16];
        y = blk[15:0];
        if (!dec) begin
            for (int i = 0; i < 32; i++) begin
                t = x;
                x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
                y = t;
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                t = y;
                y = x ^ (rol(y, 1) & rol(y, 8)) ^ rol(y, 2) ^ k[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    // Behavioural core: acknowledges after programmable delays, computes the cipher.
    initial begin : core_model
        int kc, dc;
        logic [63:0] core_key;
        logic [31:0] core_blk;
        logic        core_dec;
        kc = -1; dc = -1;
        core_key = '0; core_blk = '0; core_dec = 1'b0;
        forever begin
            @(negedge clk);
            loadKey = 1'b0; doneKey = 1'b0; loadData = 1'b0; doneData = 1'b0;
            if (readData) rd_cycles++;
            if (newData) nd_cycles++;
            if (R) begin
                kc = -1; dc = -1;
            end else begin
                if (kc >= 0) kc++;
                else if (newKey) kc = 0;
                if (kc >= 0) begin
                    chk("newKey_hold", newKey, kc <= k_ld);
                    if (kc == k_ld) begin loadKey = 1'b1; core_key = key; end
                    if (kc == k_dn) begin doneKey = 1'b1; kc = -1; end
                end
                if (dc >= 0) dc++;
                else if (newData) dc = 0;
                if (dc >= 0) begin
                    chk("newData_hold", newData, dc <= d_ld);
                    if (dc == d_ld) begin loadData = 1'b1; core_blk = inData; core_dec = enc_dec; end
                    if (dc == d_dn) begin
                        doneData = 1'b1;
                        outData  = simon(core_key, core_blk, core_dec);
                        dc = -1;
                    end
                end
            end
        end
    end

    // All tasks start and end at a negedge.
    task automatic send_word(input logic [15:0] w, input logic is_key, input logic dec);
        int  budget = 50;
        bit  done = 0;
        in_word = w; in_is_key = is_key; in_dec = dec; in_valid = 1'b1;
        while (!done && budget > 0) begin
            if (in_ready) done = 1;
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        if (!done) chk("send_word_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_key(input logic [63:0] k);
        for (int i = 0; i < M; i++) begin
            send_word(k[63-16*i -: 16], (i == 0) ? 1'b1 : 1'($urandom), 1'($urandom));
            if (i == 0) chk("key_ok_cleared", key_ok, 1'b0);
        end
        exp_key = k;
    endtask

    task automatic wait_idle();
        int b = 100;
        while (busy && b > 0) begin @(negedge clk); b--; end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic run_data(input logic [31:0] blk, input logic dec, input int hold, input logic [31:0] exp);
        int   rd0, b, w;
        logic rd_prev;
        rd0 = rd_cycles;
        send_word(blk[31:16], 1'b0, dec);
        send_word(blk[15:0], 1'($urandom), 1'($urandom));
        chk("newData_latency", newData, 1'b1);
        b = 200; rd_prev = 1'b0;
        while (!out_valid && b > 0) begin rd_prev = readData; @(negedge clk); b--; end
        chk("out_valid_seen", out_valid, 1'b1);
        chk("readData_to_out_valid", rd_prev, 1'b1);
        w = 0; b = 100;
        while (w < 2 && b > 0) begin
            if (hold > 0) begin
                out_ready = 1'b0; hold--;
                chk("in_ready_in_out", in_ready, 1'b0);
            end else begin
                out_ready = 1'($urandom);
            end
            chk("out_valid_held", out_valid, 1'b1);
            chk("out_word", out_word, (w == 0) ? exp[31:16] : exp[15:0]);
            if (out_ready) w++;
            @(negedge clk);
            b--;
        end
        out_ready = 1'b0;
        chk("out_done", w, 2);
        chk("idle_after_out", {busy, out_valid}, 2'b00);
        chk("readData_one_cycle", rd_cycles - rd0, 1);
        chk("enc_dec_kept", enc_dec, dec);
    endtask

    initial begin : stimulus
        logic [63:0] nk;
        logic [31:0] blk;
        logic        dec;

        // Reset: every output is 0 while R is held.
        R = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {in_ready, out_valid, out_word, key_ok, busy, err, newKey, newData,
                              enc_dec, readData, key, inData}, '0);
        R = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {in_ready, busy}, 2'b10);

        // Data with no key loaded.
        send_word(16'h1234, 1'b0, 1'b0);
        send_word(16'h5678, 1'b1, 1'b0);
        chk("nokey_err", {err, in_ready, newData, busy}, 4'b1100);
        @(negedge clk);
        chk("nokey_err_pulse", err, 1'b0);
        chk("nokey_no_newData", nd_cycles, 0);

        // Directed key load.
        k_ld = 2; k_dn = 5;
        send_key(64'h1918_1110_0908_0100);
        wait_idle();
        chk("key_value", key, 64'h1918_1110_0908_0100);
        chk("key_ok_set", key_ok, 1'b1);

        // Directed encrypt, decrypt, back-pressure.
        d_ld = 1; d_dn = 4;
        run_data(32'h6565_6877, 1'b0, 0, 32'hc69b_e9bb);
        run_data(32'hc69b_e9bb, 1'b1, 0, 32'h6565_6877);
        run_data(32'h6565_6877, 1'b0, 10, 32'hc69b_e9bb);

        // Randomized mix of key loads and data blocks.
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                k_ld = $urandom_range(0, 3);
                k_dn = k_ld + $urandom_range(0, 4);
                nk = {$urandom, $urandom};
                send_key(nk);
                wait_idle();
                chk("rand_key_value", key, nk);
                chk("rand_key_ok", key_ok, 1'b1);
            end else begin
                d_ld = $urandom_range(0, 3);
                d_dn = d_ld + $urandom_range(1, 4);
                blk = $urandom;
                dec = 1'($urandom);
                run_data(blk, dec, $urandom_range(0, 3), simon(exp_key, blk, dec));
            end
        end

        // Reset while waiting for doneData.
        d_ld = 0; d_dn = 1000;
        send_word(16'hAAAA, 1'b0, 1'b1);
        send_word(16'h5555, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("in_dwait_busy", busy, 1'b1);
        R = 1'b1;
        @(negedge clk);
        chk("midop_reset_outputs", {in_ready, out_valid, out_word, key_ok, busy, err, newKey, newData,
                                    enc_dec, readData, key, inData}, '0);
        R = 1'b0;
        @(negedge clk);
        d_ld = 1; d_dn = 3;
        send_word(16'h0001, 1'b0, 1'b0);
        send_word(16'h0002, 1'b0, 1'b0);
        chk("key_reload_needed", {err, newData}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/simon_host_if.md
Name: simon_host_if

Overview:
- Host-side initiator for the SIMON 32/64 core handshake. It drives newKey/newData/enc_dec/readData and the key/inData buses, and consumes loadKey/loadData/doneKey/doneData/outData.
- A narrow word stream (valid/ready, one N-bit word per beat) is assembled into a key or a data block and issued to the core.
- The result block is captured and streamed back out word by word.
- It sits between the system bus/test harness and the cipher top.

Parameters:
- N, 16, word width (bits).
- M, 4, key words.
- TIMEOUT, 255, core response limit in cycles (used only with the optional feature).
- TW, 8, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock
- R  in  1  reset, synchronous, active-high
- in_valid  in  1  host word valid
- in_ready  out  1  host word accepted when in_valid&in_ready
- in_word  in  N  host word
- in_is_key  in  1  sampled on the first word of a transfer: 1=key, 0=data
- in_dec  in  1  sampled on the first data word: 1=decrypt
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts the result word
- out_word  out  N  result word
- key_ok  out  1  a key is loaded in the core
- busy  out  1  not in S_IDLE
- err  out  1  one-cycle pulse: data requested with no key, or timeout
- newKey, newData  out  1  requests to core
- enc_dec  out  1  core direction
- readData  out  1  result consumed pulse
- key  out  M*N  key to core
- inData  out  2*N  block to core
- loadKey, loadData, doneKey, doneData  in  1  core acks
- outData  in  2*N  core result

Behaviour:
- Reset (R=1 at a clk edge): state S_IDLE.
  - All outputs 0.
  - key, inData and the word counter are 0.
  - key_ok=0, so a key must be reloaded after any reset, including a reset mid-operation.
  - A core request in flight is abandoned: newKey/newData drop on the next edge.
- States:
  - S_IDLE, S_COLLECT, S_KREQ, S_KWAIT, S_DREQ, S_DWAIT, S_READ, S_OUT.
  - in_ready=1 only in S_IDLE and S_COLLECT.
- First word in S_IDLE:
  - Latch type = in_is_key and dir = in_dec, then go to S_COLLECT.
  - in_is_key on later words is ignored.
- Word order:
  - Key: first word goes to key[M-1], last to key[0].
  - Data: first word goes to inData[1], second to inData[0].
- A key transfer clears key_ok on its first accepted word.
- Last word accepted:
  - Key: next state S_KREQ.
  - Data with key_ok=1: next state S_DREQ.
  - Data with key_ok=0: block dropped, err pulses 1 cycle, return to S_IDLE.
- S_KREQ: newKey=1, held until loadKey is sampled 1.
  - Next state S_KWAIT. If doneKey is also 1 that cycle, set key_ok and go to S_IDLE.
- S_KWAIT: newKey=0. On doneKey=1, set key_ok=1 and go to S_IDLE.
- S_DREQ: newData=1, enc_dec=dir, held until loadData=1; then go to S_DWAIT.
- S_DWAIT:
  - On doneData=1, register outData into the result buffer in that same edge.
  - Next state S_READ.
- S_READ: readData=1 for exactly one cycle; next state S_OUT.
- S_OUT:
  - out_valid=1 with out_word=buf[1], then buf[0]. Each word advances on out_valid&out_ready.
  - After the second word, go to S_IDLE.
  - Back-pressure holds out_word stable indefinitely.
- Core-side outputs are registered; no combinational path from in_* to core outputs.
- enc_dec keeps its value outside S_DREQ; it is changed only on new data.
- Latency:
  - Last input word to newData=1: 1 cycle.
  - doneData to readData=1: 1 cycle.
  - readData to out_valid=1: 1 cycle.

Optional Feature:
- SIMON_HOST_TIMEOUT_EN defined:
  - A TW-bit counter clears on entry to S_KREQ, S_KWAIT, S_DREQ and S_DWAIT, and increments each cycle in those states.
  - When it reaches TIMEOUT: drop newKey/newData, pulse err, clear key_ok on a key timeout, return to S_IDLE.
- Undefined: no counter; those states wait indefinitely.

Test Plan:
- Key load: words 1918,1110,0908,0100 with in_is_key=1; core acks loadKey after 2 cycles and doneKey after 5 -> key=1918_1110_0908_0100, newKey high until the loadKey cycle, key_ok=1.
- Encrypt against the SIMON_3264 core after the key load: data 6565,6877, in_dec=0 -> out_word c69b then e9bb; readData high exactly 1 cycle.
- Decrypt: data c69b,e9bb, in_dec=1 -> out 6565 then 6877.
- Data sent after reset without a key load -> err pulse, newData never asserted, in_ready=1 next cycle.
- out_ready held 0 for 10 cycles in S_OUT -> out_word stays c69b, in_ready=0; release -> c69b, e9bb, then S_IDLE.
- R asserted in S_DWAIT -> all outputs 0 next cycle, key_ok=0. With SIMON_HOST_TIMEOUT_EN and TIMEOUT=20, loadData never arriving -> err pulse 20 cycles after S_DREQ entry.
